// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
//   Shared helpers for the video pattern generator:
//     - clog2()            : ceiling log2, minimum result 1 (no zero-width buses)
//     - h_total()/v_total(): raster totals from the four timing parameters
//     - BAR_COLOURS        : 3-bit {red, green, blue} code for each of the
//                            eight colour bars, left to right
// ---------------------------------------------------------------------------
package video_timing_pkg;

  localparam int BAR_COUNT = 8;

  // Indexed by bar number; element 0 is the leftmost bar.
  // Order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [BAR_COUNT-1:0][2:0] BAR_COLOURS = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  localparam logic [2:0] BORDER_COLOUR = 3'b100;  // full-scale red

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int w = value - 1; w > 0; w = w >> 1) begin
      result++;
    end
    return (result == 0) ? 1 : result;
  endfunction

  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// ---------------------------------------------------------------------------
// video_timing_counter
//   Horizontal/vertical raster counters and the decode of the current
//   position. Decode outputs are combinational views of the counters; the
//   parent registers them so everything leaves the block aligned.
//
//   Ports
//     i_Clk     pixel clock (rising edge)
//     i_nRst    asynchronous active-low reset
//     i_Enable  counters advance only when high
//     o_H/o_V   current horizontal / vertical position
//     o_Active  position is inside the visible area
//     o_HSync   horizontal sync window (active high)
//     o_VSync   vertical sync window (active high)
// ---------------------------------------------------------------------------
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int C_H_ACTIVE = 640,
  parameter int C_H_FRONT  = 16,
  parameter int C_H_SYNC   = 96,
  parameter int C_H_BACK   = 48,
  parameter int C_V_ACTIVE = 480,
  parameter int C_V_FRONT  = 10,
  parameter int C_V_SYNC   = 2,
  parameter int C_V_BACK   = 33,
  localparam int H_TOTAL = h_total(C_H_ACTIVE, C_H_FRONT, C_H_SYNC, C_H_BACK),
  localparam int V_TOTAL = v_total(C_V_ACTIVE, C_V_FRONT, C_V_SYNC, C_V_BACK),
  localparam int HW      = clog2(H_TOTAL),
  localparam int VW      = clog2(V_TOTAL)
) (
  input  logic          i_Clk,
  input  logic          i_nRst,
  input  logic          i_Enable,
  output logic [HW-1:0] o_H,
  output logic [VW-1:0] o_V,
  output logic          o_Active,
  output logic          o_HSync,
  output logic          o_VSync
);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(C_H_ACTIVE);
  localparam logic [VW-1:0] V_ACT      = VW'(C_V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(C_H_ACTIVE + C_H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(C_H_ACTIVE + C_H_FRONT + C_H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(C_V_ACTIVE + C_V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(C_V_ACTIVE + C_V_FRONT + C_V_SYNC);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      o_H <= '0;
      o_V <= '0;
    end else if (i_Enable) begin
      if (o_H == H_LAST) begin
        o_H <= '0;
        o_V <= (o_V == V_LAST) ? '0 : o_V + 1'b1;
      end else begin
        o_H <= o_H + 1'b1;
      end
    end
  end

  assign o_Active = (o_H < H_ACT) && (o_V < V_ACT);
  assign o_HSync  = (o_H >= HS_START) && (o_H < HS_END);
  assign o_VSync  = (o_V >= VS_START) && (o_V < VS_END);

endmodule

// File: rtl/video_pattern_generator.sv
// ---------------------------------------------------------------------------
// video_pattern_generator
//   Raster timing, active-low syncs and an eight-bar colour test pattern.
//   Every output is registered one cycle after the decode of the current
//   position, so sync, enable, colour and X/Y stay mutually aligned.
//
//   Build option: define VIDEO_PATTERN_BORDER_EN to paint a one-pixel red
//   frame around the visible area. Timing is unchanged by the option.
//
//   Ports
//     i_Clk            pixel clock (rising edge)
//     i_nRst           asynchronous active-low reset
//     i_Enable         advance the raster; low gives idle outputs, X/Y hold
//     o_OutputEnable   current output pixel is in the visible area
//     o_Red/Green/Blue pixel components, C_COMPONENT_DEPTH bits each
//     o_nHSync         active-low horizontal sync
//     o_nVSync         active-low vertical sync
//     o_X/o_Y          position of the current output pixel
//     o_FrameStart     one-cycle pulse while pixel (0,0) is output
// ---------------------------------------------------------------------------
module video_pattern_generator
  import video_timing_pkg::*;
#(
  parameter int C_COMPONENT_DEPTH = 8,
  parameter int C_H_ACTIVE = 640,
  parameter int C_H_FRONT  = 16,
  parameter int C_H_SYNC   = 96,
  parameter int C_H_BACK   = 48,
  parameter int C_V_ACTIVE = 480,
  parameter int C_V_FRONT  = 10,
  parameter int C_V_SYNC   = 2,
  parameter int C_V_BACK   = 33,
  localparam int H_TOTAL = h_total(C_H_ACTIVE, C_H_FRONT, C_H_SYNC, C_H_BACK),
  localparam int V_TOTAL = v_total(C_V_ACTIVE, C_V_FRONT, C_V_SYNC, C_V_BACK),
  localparam int HW      = clog2(H_TOTAL),
  localparam int VW      = clog2(V_TOTAL)
) (
  input  logic                         i_Clk,
  input  logic                         i_nRst,
  input  logic                         i_Enable,
  output logic                         o_OutputEnable,
  output logic [C_COMPONENT_DEPTH-1:0] o_Red,
  output logic [C_COMPONENT_DEPTH-1:0] o_Green,
  output logic [C_COMPONENT_DEPTH-1:0] o_Blue,
  output logic                         o_nHSync,
  output logic                         o_nVSync,
  output logic [HW-1:0]                o_X,
  output logic [VW-1:0]                o_Y,
  output logic                         o_FrameStart
);

  localparam int BAR_W = C_H_ACTIVE / BAR_COUNT;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active;
  logic          hsync;
  logic          vsync;

  video_timing_counter #(
    .C_H_ACTIVE (C_H_ACTIVE),
    .C_H_FRONT  (C_H_FRONT),
    .C_H_SYNC   (C_H_SYNC),
    .C_H_BACK   (C_H_BACK),
    .C_V_ACTIVE (C_V_ACTIVE),
    .C_V_FRONT  (C_V_FRONT),
    .C_V_SYNC   (C_V_SYNC),
    .C_V_BACK   (C_V_BACK)
  ) u_timing (
    .i_Clk    (i_Clk),
    .i_nRst   (i_nRst),
    .i_Enable (i_Enable),
    .o_H      (h),
    .o_V      (v),
    .o_Active (active),
    .o_HSync  (hsync),
    .o_VSync  (vsync)
  );

  // Bar index saturates at the last bar so any remainder columns from the
  // integer division stay black rather than wrapping to white.
  logic [HW-1:0] bar_quot;
  logic [2:0]    bar_idx;
  logic          on_border;
  logic [2:0]    pix_code;

  assign bar_quot = h / HW'(BAR_W);
  assign bar_idx  = (bar_quot > HW'(BAR_COUNT - 1)) ? 3'(BAR_COUNT - 1) : bar_quot[2:0];

`ifdef VIDEO_PATTERN_BORDER_EN
  localparam logic [HW-1:0] H_EDGE = HW'(C_H_ACTIVE - 1);
  localparam logic [VW-1:0] V_EDGE = VW'(C_V_ACTIVE - 1);
  assign on_border = (h == '0) || (h == H_EDGE) || (v == '0) || (v == V_EDGE);
`else
  assign on_border = 1'b0;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pix_code = 3'b000;
    if (active) begin
      pix_code = on_border ? BORDER_COLOUR : BAR_COLOURS[bar_idx];
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      o_OutputEnable <= 1'b0;
      o_Red          <= '0;
      o_Green        <= '0;
      o_Blue         <= '0;
      o_nHSync       <= 1'b1;
      o_nVSync       <= 1'b1;
      o_X            <= '0;
      o_Y            <= '0;
      o_FrameStart   <= 1'b0;
    end else if (i_Enable) begin
      o_OutputEnable <= active;
      o_Red          <= {C_COMPONENT_DEPTH{pix_code[2]}};
      o_Green        <= {C_COMPONENT_DEPTH{pix_code[1]}};
      o_Blue         <= {C_COMPONENT_DEPTH{pix_code[0]}};
      o_nHSync       <= ~hsync;
      o_nVSync       <= ~vsync;
      o_X            <= h;
      o_Y            <= v;
      o_FrameStart   <= (h == '0) && (v == '0);
    end else begin
      // Idle while paused; X/Y keep the last presented position.
      o_OutputEnable <= 1'b0;
      o_Red          <= '0;
      o_Green        <= '0;
      o_Blue         <= '0;
      o_nHSync       <= 1'b1;
      o_nVSync       <= 1'b1;
      o_FrameStart   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_pattern_generator.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_generator
//   Directed bench. Horizontal timing uses the 640x480 defaults; the vertical
//   timing is shortened (24 active, 3 front, 2 sync, 4 back = 33 lines) so a
//   whole frame fits in a short run. The line numbers used below scale with
//   that: vsync lines 27..28, last active line 23.
// ---------------------------------------------------------------------------
module tb_video_pattern_generator;

  localparam int H_TOT    = 800;
  localparam int H_ACT    = 640;
  localparam int V_ACT    = 24;
  localparam int V_TOT    = 33;
  localparam int VS_FIRST = 27;
  localparam int VS_LAST  = 28;
  localparam int FRAME    = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        o_OutputEnable;
  logic [7:0]  o_Red, o_Green, o_Blue;
  logic        o_nHSync, o_nVSync;
  logic [9:0]  o_X;
  logic [5:0]  o_Y;
  logic        o_FrameStart;
  logic [23:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;
  int nx = 0, ny = 0;  // next pixel the raster will present
  int ex = 0, ey = 0;  // pixel expected on the outputs now

  assign rgb = {o_Red, o_Green, o_Blue};

  always #5 clk = ~clk;

  video_pattern_generator #(
    .C_V_ACTIVE (24),
    .C_V_FRONT  (3),
    .C_V_SYNC   (2),
    .C_V_BACK   (4)
  ) dut (
    .i_Clk          (clk),
    .i_nRst         (rst_n),
    .i_Enable       (en),
    .o_OutputEnable (o_OutputEnable),
    .o_Red          (o_Red),
    .o_Green        (o_Green),
    .o_Blue         (o_Blue),
    .o_nHSync       (o_nHSync),
    .o_nVSync       (o_nVSync),
    .o_X            (o_X),
    .o_Y            (o_Y),
    .o_FrameStart   (o_FrameStart)
  );

  // One clock; sample 1 ns after the edge. Position model advances only
  // when enabled.
  task automatic step();
    @(posedge clk);
    #1;
    if (en) begin
      ex = nx;
      ey = ny;
      if (nx == H_TOT - 1) begin
        nx = 0;
        ny = (ny == V_TOT - 1) ? 0 : ny + 1;
      end else begin
        nx = nx + 1;
      end
    end
  endtask

  // Step until the raster's next pixel is (x,y), i.e. (x-1,y) is on the outputs.
  task automatic goto(input int x, input int y);
    int guard = 0;
    while (!(nx == x && ny == y) && guard < FRAME + 1) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard > FRAME) begin
      n_fail++;
      $display("FAIL goto: position (%0d,%0d) not reached, now (%0d,%0d)", x, y, nx, ny);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart} !== 4'b0110) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0110",
               {o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart});
    end
    n_checks++;
    if (rgb !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_rgb: got %h expected 000000", rgb);
    end
    n_checks++;
    if (o_X !== 10'd0 || o_Y !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", o_X, o_Y);
    end
    rst_n = 1'b1;
    nx = 0; ny = 0; ex = 0; ey = 0;
    // Released but disabled: still idle.
    step();
    n_checks++;
    if ({o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart} !== 4'b0110 || o_X !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got ctrl %b x %0d expected 0110 x 0",
               {o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart}, o_X);
    end
  endtask

  task automatic test_first_line();
    int          oe_cnt = 0;
    int          xs [6] = '{0, 80, 160, 480, 560, 639};
    logic [23:0] cols [6] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                              24'h0000FF, 24'h000000, 24'h000000};
    en = 1'b1;
    for (int c = 1; c <= H_TOT; c++) begin
      step();
      if (o_OutputEnable) oe_cnt++;
      n_checks++;
      if (o_FrameStart !== (c == 1)) begin
        n_fail++;
        $display("FAIL line_fs: cycle %0d got %b expected %b", c, o_FrameStart, c == 1);
      end
      n_checks++;
      if (o_nHSync !== !(c >= 657 && c <= 752)) begin
        n_fail++;
        $display("FAIL line_hsync: cycle %0d got %b expected %b", c, o_nHSync,
                 !(c >= 657 && c <= 752));
      end
      n_checks++;
      if (o_OutputEnable !== (c <= H_ACT) || o_nVSync !== 1'b1) begin
        n_fail++;
        $display("FAIL line_oe_vs: cycle %0d got oe %b vs %b expected oe %b vs 1",
                 c, o_OutputEnable, o_nVSync, c <= H_ACT);
      end
      n_checks++;
      if (o_X !== 10'(c - 1) || o_Y !== 6'd0) begin
        n_fail++;
        $display("FAIL line_xy: cycle %0d got (%0d,%0d) expected (%0d,0)", c, o_X, o_Y, c - 1);
      end
      for (int k = 0; k < 6; k++) begin
        if (c - 1 == xs[k]) begin
          n_checks++;
          if (rgb !== cols[k]) begin
            n_fail++;
            $display("FAIL bar_x%0d: got %h expected %h", xs[k], rgb, cols[k]);
          end
        end
      end
    end
    n_checks++;
    if (oe_cnt !== H_ACT) begin
      n_fail++;
      $display("FAIL line_oe_count: got %0d expected %0d", oe_cnt, H_ACT);
    end
  endtask

  task automatic test_full_frame();
    int vs_low = 0, first_vs_y = -1, oe_late = 0, fs_cnt = 0, fs_at = -1;
    for (int c = H_TOT + 1; c <= FRAME + 1; c++) begin
      step();
      n_checks++;
      if (o_X !== 10'(ex) || o_Y !== 6'(ey)) begin
        n_fail++;
        $display("FAIL frame_xy: cycle %0d got (%0d,%0d) expected (%0d,%0d)", c, o_X, o_Y, ex, ey);
      end
      n_checks++;
      if (o_nVSync !== !(ey >= VS_FIRST && ey <= VS_LAST)) begin
        n_fail++;
        $display("FAIL frame_vsync: line %0d got %b expected %b", ey, o_nVSync,
                 !(ey >= VS_FIRST && ey <= VS_LAST));
      end
      if (!o_nVSync) begin
        vs_low++;
        if (first_vs_y < 0) first_vs_y = int'(o_Y);
      end
      if (o_OutputEnable && ey >= V_ACT) oe_late++;
      if (o_FrameStart) begin
        fs_cnt++;
        fs_at = c;
      end
    end
    n_checks++;
    if (vs_low !== 2 * H_TOT || first_vs_y !== VS_FIRST) begin
      n_fail++;
      $display("FAIL frame_vsync_span: got %0d cycles from y=%0d expected %0d from y=%0d",
               vs_low, first_vs_y, 2 * H_TOT, VS_FIRST);
    end
    n_checks++;
    if (oe_late !== 0) begin
      n_fail++;
      $display("FAIL frame_oe_blank: got %0d active cycles below visible area expected 0", oe_late);
    end
    n_checks++;
    if (fs_cnt !== 1 || fs_at !== FRAME + 1) begin
      n_fail++;
      $display("FAIL frame_restart: got %0d pulses last at cycle %0d expected 1 at %0d",
               fs_cnt, fs_at, FRAME + 1);
    end
    n_checks++;
    if (o_OutputEnable !== 1'b1 || rgb !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL frame_wrap_pixel: got oe %b rgb %h expected 1 FFFFFF", o_OutputEnable, rgb);
    end
  endtask

  task automatic test_pause();
    goto(300, 10);
    n_checks++;
    if (o_X !== 10'd299 || o_Y !== 6'd10) begin
      n_fail++;
      $display("FAIL pause_pre: got (%0d,%0d) expected (299,10)", o_X, o_Y);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart} !== 4'b0110 || rgb !== 24'h0) begin
        n_fail++;
        $display("FAIL pause_idle: gap %0d got ctrl %b rgb %h expected 0110 000000",
                 i, {o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart}, rgb);
      end
      n_checks++;
      if (o_X !== 10'd299 || o_Y !== 6'd10) begin
        n_fail++;
        $display("FAIL pause_hold: gap %0d got (%0d,%0d) expected (299,10)", i, o_X, o_Y);
      end
    end
    en = 1'b1;
    step();
    n_checks++;
    if (o_X !== 10'd300 || o_Y !== 6'd10 || o_OutputEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume: got (%0d,%0d) oe %b expected (300,10) oe 1",
               o_X, o_Y, o_OutputEnable);
    end
    n_checks++;
    if (rgb !== 24'h00FF00) begin  // x=300 is bar 3, green
      n_fail++;
      $display("FAIL pause_colour: got %h expected 00FF00", rgb);
    end
    goto(1, 11);
    n_checks++;
    if (o_X !== 10'd0 || o_Y !== 6'd11) begin
      n_fail++;
      $display("FAIL pause_next_line: got (%0d,%0d) expected (0,11)", o_X, o_Y);
    end
  endtask

  task automatic test_reset_mid();
    goto(201, 20);
    n_checks++;
    if (o_X !== 10'd200 || o_Y !== 6'd20 || o_OutputEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got (%0d,%0d) oe %b expected (200,20) oe 1",
               o_X, o_Y, o_OutputEnable);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart} !== 4'b0110 || rgb !== 24'h0 ||
        o_X !== 10'd0 || o_Y !== 6'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got ctrl %b rgb %h (%0d,%0d) expected 0110 000000 (0,0)",
               {o_OutputEnable, o_nHSync, o_nVSync, o_FrameStart}, rgb, o_X, o_Y);
    end
    nx = 0; ny = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (o_X !== 10'd0 || o_Y !== 6'd0 || o_FrameStart !== 1'b1 || o_OutputEnable !== 1'b1 ||
        rgb !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL rstmid_first: got (%0d,%0d) fs %b oe %b rgb %h expected (0,0) 1 1 FFFFFF",
               o_X, o_Y, o_FrameStart, o_OutputEnable, rgb);
    end
    step();
    n_checks++;
    if (o_X !== 10'd1 || o_FrameStart !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_second: got x %0d fs %b expected x 1 fs 0", o_X, o_FrameStart);
    end
  endtask

`ifdef VIDEO_PATTERN_BORDER_EN
  task automatic test_border();
    int          px [5] = '{5, 0, 5, 639, 5};
    int          py [5] = '{0, 5, 5, 5, 23};
    logic [23:0] pc [5] = '{24'hFF0000, 24'hFF0000, 24'hFFFFFF, 24'hFF0000, 24'hFF0000};
    for (int k = 0; k < 5; k++) begin
      goto(px[k] + 1, py[k]);
      n_checks++;
      if (rgb !== pc[k] || o_X !== 10'(px[k]) || o_Y !== 6'(py[k])) begin
        n_fail++;
        $display("FAIL border_%0d_%0d: got %h at (%0d,%0d) expected %h", px[k], py[k],
                 rgb, o_X, o_Y, pc[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_line();
    test_full_frame();
    test_pause();
    test_reset_mid();
`ifdef VIDEO_PATTERN_BORDER_EN
    test_border();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
